// File: rtl/exec_cc_stage.sv
// rtl/exec_cc_stage.sv - Y86 execute-stage condition codes, jXX/cmovXX evaluation and E->M pipeline register
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   E_stat/E_icode/E_ifun       instruction in execute
//   E_valA, E_dstE, E_dstM      operand A and destinations carried to memory
//   alu_res, alu_zf/sf/of       ALU result and flags for the current operation
//   m_stat, W_stat              status in memory / writeback (gate CC writes)
//   M_stall, M_bubble           M register control (stall wins over bubble)
//   e_Cnd, e_dstE               combinational condition and effective dstE
//   cc_zf, cc_sf, cc_of         condition-code register
//   M_*                         execute->memory pipeline register
module exec_cc_stage #(
   parameter logic [3:0] RNONE    = 4'hF,
   parameter logic [3:0] ST_AOK   = 4'd1,
   parameter logic [3:0] ST_HLT   = 4'd2,
   parameter logic [3:0] ST_ADR   = 4'd3,
   parameter logic [3:0] ST_INS   = 4'd4,
   parameter logic [3:0] I_NOP    = 4'd1,
   parameter logic [3:0] I_RRMOVQ = 4'd2,
   parameter logic [3:0] I_OPQ    = 4'd6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  E_stat,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  E_ifun,
   input  logic [63:0] E_valA,
   input  logic [3:0]  E_dstE,
   input  logic [3:0]  E_dstM,
   input  logic [63:0] alu_res,
   input  logic        alu_zf,
   input  logic        alu_sf,
   input  logic        alu_of,
   input  logic [3:0]  m_stat,
   input  logic [3:0]  W_stat,
   input  logic        M_stall,
   input  logic        M_bubble,
   output logic        e_Cnd,
   output logic [3:0]  e_dstE,
   output logic        cc_zf,
   output logic        cc_sf,
   output logic        cc_of,
   output logic [3:0]  M_stat,
   output logic [3:0]  M_icode,
   output logic        M_Cnd,
   output logic [63:0] M_valE,
   output logic [63:0] M_valA,
   output logic [3:0]  M_dstE,
   output logic [3:0]  M_dstM
);

   logic sf_xor_of;
   logic m_exc;
   logic w_exc;
   logic set_cc;

   // Condition is evaluated from the architectural CC, never from the live ALU flags.
   assign sf_xor_of = cc_sf ^ cc_of;

   always_comb begin
      e_Cnd = 1'b0;
      case (E_ifun)
         4'd0:    e_Cnd = 1'b1;
         4'd1:    e_Cnd = sf_xor_of | cc_zf;
         4'd2:    e_Cnd = sf_xor_of;
         4'd3:    e_Cnd = cc_zf;
         4'd4:    e_Cnd = ~cc_zf;
         4'd5:    e_Cnd = ~sf_xor_of;
         4'd6:    e_Cnd = ~sf_xor_of & ~cc_zf;
         default: e_Cnd = 1'b0;
      endcase
   end

   // A cmov whose condition fails must not write back nor be forwarded.
   assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

   assign m_exc  = (m_stat == ST_HLT) || (m_stat == ST_ADR) || (m_stat == ST_INS);
   assign w_exc  = (W_stat == ST_HLT) || (W_stat == ST_ADR) || (W_stat == ST_INS);
   assign set_cc = (E_icode == I_OPQ) && !m_exc && !w_exc;

   // CC register is not affected by M stall/bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cc_zf <= 1'b1;
         cc_sf <= 1'b0;
         cc_of <= 1'b0;
      end else if (set_cc) begin
         cc_zf <= alu_zf;
         cc_sf <= alu_sf;
         cc_of <= alu_of;
      end
   end

   // Priority: reset, stall (hold), bubble, load.
   always_ff @(posedge clk) begin
      if (!rst_n || (!M_stall && M_bubble)) begin
         M_stat  <= ST_AOK;
         M_icode <= I_NOP;
         M_Cnd   <= 1'b0;
         M_valE  <= 64'd0;
         M_valA  <= 64'd0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else if (!M_stall) begin
         M_stat  <= E_stat;
         M_icode <= E_icode;
         M_Cnd   <= e_Cnd;
         M_valE  <= alu_res;
         M_valA  <= E_valA;
         M_dstE  <= e_dstE;
         M_dstM  <= E_dstM;
      end
   end

endmodule

// File: doc/exec_cc_stage.md
# exec_cc_stage

Execute-stage back end of the 5-stage Y86 pipeline, sitting directly downstream of the ALU. Holds the architectural condition-code register (ZF/SF/OF), evaluates jXX/cmovXX conditions, and forms the execute→memory pipeline register with stall/bubble control. It also drives the combinational execute-stage destination and condition signals used by forwarding and mispredict logic.

## Interface
Parameters:
- RNONE, 4'hF, "no register" destination code
- ST_AOK / ST_HLT / ST_ADR / ST_INS, 1 / 2 / 3 / 4, status codes (4-bit)
- I_NOP / I_RRMOVQ / I_OPQ, 1 / 2 / 6, icode values used by this block

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- E_stat  in  4  status of instruction in execute
- E_icode, E_ifun  in  4, 4  instruction code / function
- E_valA  in  64  operand A passed through to memory
- E_dstE, E_dstM  in  4, 4  destination register IDs
- alu_res  in  64  ALU result (valE)
- alu_zf, alu_sf, alu_of  in  1 each  ALU flags for the current operation
- m_stat, W_stat  in  4, 4  status currently in memory / writeback stages
- M_stall, M_bubble  in  1, 1  pipeline control for the M register
- e_Cnd  out  1  combinational condition result
- e_dstE  out  4  combinational effective dstE (forwarding)
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register
- M_stat, M_icode  out  4, 4  registered
- M_Cnd  out  1  registered
- M_valE, M_valA  out  64, 64  registered
- M_dstE, M_dstM  out  4, 4  registered

## Operation
- Condition evaluation (combinational, from CC register, not from alu_* flags), by E_ifun: 0 always=1; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=!ZF; 5 ge=!(SF^OF); 6 g=!(SF^OF)&!ZF; 7–15 → 0.
- e_Cnd = evaluated condition for any icode; meaningful only for jXX (7) and cmovXX (2).
- e_dstE = RNONE when E_icode==I_RRMOVQ and e_Cnd==0; otherwise E_dstE.
- set_cc = (E_icode==I_OPQ) && m_stat∉{HLT,ADR,INS} && W_stat∉{HLT,ADR,INS}.
- CC register: on set_cc, load {alu_zf, alu_sf, alu_of}; otherwise hold. CC update is independent of M_stall/M_bubble.
- M register priority: reset > M_stall > M_bubble > normal load. M_stall and M_bubble both high → stall (hold).
- Normal load: M_stat←E_stat, M_icode←E_icode, M_Cnd←e_Cnd, M_valE←alu_res, M_valA←E_valA, M_dstE←e_dstE, M_dstM←E_dstM.
- Bubble/reset value: M_stat=ST_AOK, M_icode=I_NOP, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE.
- Widths: all 64-bit values passed unmodified; no arithmetic performed in this block.

## Timing
- Reset (rst_n low at edge): CC → ZF=1, SF=0, OF=0; M register → bubble value. Reset mid-stream discards the in-flight instruction; no CC update that cycle even if set_cc.
- e_Cnd, e_dstE: zero-cycle combinational from E_* and CC.
- CC latency: 1 cycle. An OPq in execute in cycle n updates CC at edge ending n; a jXX/cmov in execute in cycle n+1 sees the new flags. An OPq and a dependent jXX cannot be in execute together.
- M register latency: 1 cycle from E inputs; stall holds all M outputs for every stalled cycle.
- alu_res and alu_* flags must be stable before the rising edge on which the block samples them.
- Exception in m or W (HLT/ADR/INS) suppresses CC write in the same cycle only.

## Test plan
- Reset: hold rst_n=0 two edges → cc=(1,0,0), M_icode=1, M_stat=1, M_dstE=M_dstM=F, M_valE=0.
- OPq update: E_icode=6, alu_res=0, flags (1,0,0), then E_icode=7 ifun=3 → e_Cnd=1; repeat with flags (0,1,0) and ifun=2 → e_Cnd=1, ifun=6 → e_Cnd=0.
- Exception suppression: CC=(0,0,0); OPq with flags (1,0,0) while m_stat=3 → CC stays (0,0,0); next cycle m_stat=1 → CC becomes (1,0,0).
- cmov squash: CC=(0,0,0), E_icode=2 ifun=3 E_dstE=4 → e_dstE=F, next-edge M_dstE=F; ifun=4 → e_dstE=4, M_dstE=4.
- Stall/bubble: load alu_res=0x1234; assert M_stall 3 cycles with changing inputs → M_valE stays 0x1234; assert M_stall+M_bubble → hold; M_bubble alone → M_icode=1, M_valE=0.
- Reset mid-operation: OPq flags (0,0,1) with rst_n=0 on same edge → CC=(1,0,0) and M bubble value.
